// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HiLo multiply/divide unit.
// Holds op codes, FSM state encoding, divide iteration count, div-by-zero Lo.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

  localparam int          DIV_ITER = 32;
  localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;

  // Magnitude of v when treated as signed (sgn=1), else v unchanged.
  function automatic logic [31:0] abs32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Ports: clk, rst, abort_i, start_i, dividend_i, divisor_i -> done_o, quot_o, rem_o.
module mdu_div
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        abort_i,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [31:0] q_q;
  logic [31:0] r_q;
  logic [31:0] d_q;
  logic [5:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  // Returns {rem, quot} after one shift/subtract step.
  function automatic logic [63:0] div_step(
    input logic [31:0] r,
    input logic [31:0] q,
    input logic [31:0] d
  );
    logic [32:0] t;
    t = {r, q[31]} - {1'b0, d};
    if (!t[32]) return {t[31:0], q[30:0], 1'b1};
    return {r[30:0], q[31], q[30:0], 1'b0};
  endfunction

  // The first step runs on the load edge so the final
  // quotient is ready DIV_ITER-1 edges after start.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      r_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else if (start_i) begin
        {r_q, q_q} <= div_step(32'd0, dividend_i, divisor_i);
        d_q    <= divisor_i;
        cnt_q  <= 6'd1;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        {r_q, q_q} <= div_step(r_q, q_q, d_q);
        cnt_q <= cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_ITER - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign quot_o = q_q;
  assign rem_o  = r_q;

endmodule

// File: rtl/mdu_ctrl.sv
// HiLo multiply/divide controller: sequences MULT/MULTU/DIV/DIVU, stalls the pipe.
// Ports: clk, rst, start, op, opa, opb, flush -> stall, busy, wHiData/whi, wLoData/wlo.
// Divide path is built only when MDU_DIV_EN is defined.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] wHiData,
  output logic        whi,
  output logic [31:0] wLoData,
  output logic        wlo
);

  localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

  mdu_state_e  state_q;
  mdu_op_e     op_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [31:0] res_hi_q;
  logic [31:0] res_lo_q;
  logic [31:0] last_hi_q;
  logic [31:0] last_lo_q;

  logic        acc_ok;
  logic        wr_en;
  logic        ext_a;
  logic        ext_b;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] prod;

`ifdef MDU_DIV_EN
  logic        div_start;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign acc_ok = 1'b1;

  assign div_start = (state_q == S_IDLE) && start
                   && !flush && op[1] && (opb != 32'd0);

  mdu_div u_div (
    .clk        (clk),
    .rst        (rst),
    .abort_i    (flush),
    .start_i    (div_start),
    .dividend_i (abs32(opa, op == OP_DIV)),
    .divisor_i  (abs32(opb, op == OP_DIV)),
    .done_o     (div_done),
    .quot_o     (div_q),
    .rem_o      (div_r)
  );

  // Quotient sign = XOR of operand signs; remainder follows dividend.
  assign neg_q = (op_q == OP_DIV) && (opa_q[31] ^ opb_q[31]);
  assign neg_r = (op_q == OP_DIV) && opa_q[31];
  assign q_fix = neg_q ? (~div_q + 32'd1) : div_q;
  assign r_fix = neg_r ? (~div_r + 32'd1) : div_r;
`else
  assign acc_ok = ~op[1];
`endif

  // Sign/zero extend both operands to 64 bits; the low 64 bits
  // of the product are then correct for both MULT and MULTU.
  assign ext_a = (op_q == OP_MULT) && opa_q[31];
  assign ext_b = (op_q == OP_MULT) && opb_q[31];
  assign a64   = {{32{ext_a}}, opa_q};
  assign b64   = {{32{ext_b}}, opb_q};
  assign prod  = a64 * b64;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULT;
      opa_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      last_hi_q <= '0;
      last_lo_q <= '0;
    end else begin
      wr_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start && acc_ok) begin
              op_q  <= mdu_op_e'(op);
              opa_q <= opa;
              opb_q <= opb;
              cnt_q <= '0;
              if (!op[1]) begin
                state_q <= S_MUL;
`ifdef MDU_DIV_EN
              end else if (opb == 32'd0) begin
                state_q  <= S_DONE;
                wr_q     <= 1'b1;
                res_hi_q <= opa;
                res_lo_q <= DIV0_LO;
              end else begin
                state_q <= S_DIV;
`endif
              end
            end
          end
          S_MUL: begin
            if (cnt_q == CNT_LAST) begin
              state_q  <= S_DONE;
              wr_q     <= 1'b1;
              res_hi_q <= prod[63:32];
              res_lo_q <= prod[31:0];
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_DIV: begin
`ifdef MDU_DIV_EN
            if (div_done) begin
              state_q  <= S_DONE;
              wr_q     <= 1'b1;
              res_hi_q <= r_fix;
              res_lo_q <= q_fix;
            end
`else
            state_q <= S_IDLE;
`endif
          end
          S_DONE: begin
            state_q   <= S_IDLE;
            last_hi_q <= res_hi_q;
            last_lo_q <= res_lo_q;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // A flush in DONE cancels the write in that same cycle.
  assign wr_en   = wr_q & ~flush;
  assign whi     = wr_en;
  assign wlo     = wr_en;
  assign wHiData = wr_en ? res_hi_q : last_hi_q;
  assign wLoData = wr_en ? res_lo_q : last_lo_q;

  assign busy  = (state_q != S_IDLE);
  assign stall = ((state_q == S_IDLE) && start && acc_ok) || busy;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (MUL_LAT=2).
// Divide vectors run only when MDU_DIV_EN is defined.
module tb_mdu_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] wHiData;
  logic        whi;
  logic [31:0] wLoData;
  logic        wlo;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int wc0;
  int n;

  mdu_ctrl #(.MUL_LAT(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .opa     (opa),
    .opb     (opb),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .wHiData (wHiData),
    .whi     (whi),
    .wLoData (wLoData),
    .wlo     (wlo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (whi === 1'b1) wr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_wr(output int cnt);
    cnt = 0;
    while (whi !== 1'b1 && cnt < 60) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00;
    opa = '0; opb = '0; flush = 1'b0;
    tick(); tick();
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_whi", whi, 0);
    chk("rst_wlo", wlo, 0);
    chk("rst_hi", wHiData, 0);
    chk("rst_lo", wLoData, 0);
    rst = 1'b0;
    tick();

    // MULT -2 x 3, new start during MUL must be ignored
    op = 2'b00; opa = 32'hFFFF_FFFE; opb = 32'd3; start = 1'b1;
    #1;
    chk("mult_stall_comb", stall, 1);
    chk("mult_busy_pre", busy, 0);
    wc0 = wr_cnt;
    tick();
    op = 2'b01; opa = 32'h55; opb = 32'h77;
    chk("mult_busy", busy, 1);
    chk("mult_stall1", stall, 1);
    tick();
    start = 1'b0; opa = '0; opb = '0;
    chk("mult_whi_early", whi, 0);
    chk("mult_stall2", stall, 1);
    tick();
    chk("mult_whi", whi, 1);
    chk("mult_wlo", wlo, 1);
    chk("mult_hi", wHiData, 32'hFFFF_FFFF);
    chk("mult_lo", wLoData, 32'hFFFF_FFFA);
    chk("mult_stall3", stall, 1);
    tick();
    chk("mult_whi_off", whi, 0);
    chk("mult_idle", busy, 0);
    chk("mult_stall_off", stall, 0);
    chk("mult_hold_hi", wHiData, 32'hFFFF_FFFF);
    chk("mult_hold_lo", wLoData, 32'hFFFF_FFFA);
    chk("mult_one_write", wr_cnt, wc0 + 1);

    // MULTU max x max
    op = 2'b01; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_wr(n);
    chk("multu_lat", n, 2);
    chk("multu_hi", wHiData, 32'hFFFF_FFFE);
    chk("multu_lo", wLoData, 32'h0000_0001);
    tick();

    // reset in MUL cycle 1 while start re-asserted
    op = 2'b00; opa = 32'd5; opb = 32'd7; start = 1'b1;
    wc0 = wr_cnt;
    tick();
    op = 2'b01; opa = 32'd9; opb = 32'd9; rst = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_whi", whi, 0);
    chk("rstmid_hi", wHiData, 0);
    chk("rstmid_lo", wLoData, 0);
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rstmid_nowr", wr_cnt, wc0);

    // flush in MUL with start high: flush wins
    op = 2'b00; opa = 32'd4; opb = 32'd4; start = 1'b1;
    tick();
    flush = 1'b1; op = 2'b01; opa = 32'd2; opb = 32'd3;
    tick();
    chk("flmul_busy", busy, 0);
    flush = 1'b0; start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("flmul_idle", busy, 0);
    chk("flmul_nowr", wr_cnt, wc0);

    // flush in DONE suppresses the write
    op = 2'b00; opa = 32'hFFFF_FFFD; opb = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("fldone_whi_pre", whi, 1);
    flush = 1'b1;
    #1;
    chk("fldone_whi", whi, 0);
    chk("fldone_wlo", wlo, 0);
    chk("fldone_hold_hi", wHiData, 0);
    tick();
    flush = 1'b0;
    chk("fldone_busy", busy, 0);
    chk("fldone_nowr", wr_cnt, wc0);

    // recovery: MULT -3 x 5
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_wr(n);
    chk("mult2_lat", n, 2);
    chk("mult2_hi", wHiData, 32'hFFFF_FFFF);
    chk("mult2_lo", wLoData, 32'hFFFF_FFF1);
    tick();

`ifdef MDU_DIV_EN
    // DIV -7 / 2
    op = 2'b10; opa = 32'hFFFF_FFF9; opb = 32'd2; start = 1'b1;
    #1;
    chk("div_stall_comb", stall, 1);
    tick();
    start = 1'b0; opa = '0;
    wait_wr(n);
    chk("div_lat", n, 32);
    chk("div_lo", wLoData, 32'hFFFF_FFFD);
    chk("div_hi", wHiData, 32'hFFFF_FFFF);
    tick();

    // DIVU same operands
    op = 2'b11; opa = 32'hFFFF_FFF9; opb = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_wr(n);
    chk("divu_lat", n, 32);
    chk("divu_lo", wLoData, 32'h7FFF_FFFC);
    chk("divu_hi", wHiData, 32'h0000_0001);
    tick();

    // DIVU by zero
    op = 2'b11; opa = 32'h1234; opb = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_wr(n);
    chk("div0_lat", n, 0);
    chk("div0_lo", wLoData, 32'hFFFF_FFFF);
    chk("div0_hi", wHiData, 32'h0000_1234);
    tick();

    // DIV overflow case
    op = 2'b10; opa = 32'h8000_0000; opb = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_wr(n);
    chk("divovf_lo", wLoData, 32'h8000_0000);
    chk("divovf_hi", wHiData, 32'h0000_0000);
    tick();

    // flush at DIV cycle 10 with start high
    op = 2'b10; opa = 32'd100; opb = 32'd3; start = 1'b1;
    wc0 = wr_cnt;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("fldiv_busy_pre", busy, 1);
    flush = 1'b1; start = 1'b1; op = 2'b00; opa = 32'd6; opb = 32'd6;
    tick();
    chk("fldiv_busy", busy, 0);
    flush = 1'b0; start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("fldiv_idle", busy, 0);
    chk("fldiv_nowr", wr_cnt, wc0);
`else
    // divide disabled: DIV start is a no-op
    op = 2'b10; opa = 32'd100; opb = 32'd7; start = 1'b1;
    wc0 = wr_cnt;
    #1;
    chk("nodiv_stall_comb", stall, 0);
    tick();
    chk("nodiv_busy", busy, 0);
    chk("nodiv_stall", stall, 0);
    start = 1'b0;
    tick(); tick(); tick();
    chk("nodiv_busy2", busy, 0);
    chk("nodiv_nowr", wr_cnt, wc0);
    chk("nodiv_hold_hi", wHiData, 32'hFFFF_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
